// File: rtl/simulation_result_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : simulation_result_stream_sink
//  Purpose  : Receiving end of the accelerator's outbound DMA-write stream.
//             Arms on DMA_write_valid and accepts exactly expect_num beats.
//             Every accepted beat is folded into a 32-bit rotating checksum.
//             The block flags completion (done / done_flag) or a stall
//             timeout (error).
//  Ports    : clk, rst (async, active-low)
//             DMA_write_valid, expect_num      - start request / beat count
//             S_Data, S_Valid, S_Ready         - inbound stream
//             beat_cnt, checksum               - progress and signature
//             busy, done, done_flag, error     - status
//  Option   : SIM_SINK_STALL_INJECT_EN - when defined, an LFSR deasserts
//             S_Ready on roughly 25% of RECV cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module simulation_result_stream_sink #(
  parameter int          DATA_WIDTH     = 256,
  parameter int          CNT_WIDTH      = 21,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DMA_write_valid,
  input  logic [CNT_WIDTH-1:0]  expect_num,
  input  logic [DATA_WIDTH-1:0] S_Data,
  input  logic                  S_Valid,
  output logic                  S_Ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [31:0]           checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  done_flag,
  output logic                  error
);

  localparam int N_WORDS = DATA_WIDTH / 32;
  localparam int TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   expect_q, expect_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]            checksum_q, checksum_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   done_q, done_d;
  logic                   done_flag_q, done_flag_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  logic                   stall;
  logic                   accept;
  logic                   start;
  logic [31:0]            fold;

  // --------------------------------------------------------------------------
  // Ready-throttling source
  // --------------------------------------------------------------------------
`ifdef SIM_SINK_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10)
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = lfsr_q;
    if (state_q == RECV) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic seed_unused;
  assign seed_unused = ^LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Word fold: XOR of all 32-bit lanes of the current beat
  // --------------------------------------------------------------------------
  always_comb begin
    fold = 32'd0;
    for (int i = 0; i < N_WORDS; i++) begin
      fold = fold ^ S_Data[32*i +: 32];
    end
  end

  assign S_Ready = (state_q == RECV) & ~stall;
  assign accept  = S_Valid & S_Ready;
  // Start requests are only honoured outside RECV.
  assign start   = DMA_write_valid & (state_q != RECV);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    beat_cnt_d  = beat_cnt_q;
    checksum_d  = checksum_q;
    tmo_d       = tmo_q;
    done_flag_d = done_flag_q;
    error_d     = error_q;

    case (state_q)
      RECV: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          checksum_d = {checksum_q[30:0], checksum_q[31]} ^ fold;
          tmo_d      = '0;
          if ((beat_cnt_q + CNT_WIDTH'(1)) == expect_q) begin
            state_d     = DONE;
            done_flag_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // An accept on this same edge would have taken the branch above.
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        if (start) begin
          expect_d    = expect_num;
          beat_cnt_d  = '0;
          checksum_d  = '0;
          tmo_d       = '0;
          error_d     = 1'b0;
          done_flag_d = 1'b0;
          if (expect_num == '0) begin
            // Nothing to receive: complete immediately.
            state_d     = DONE;
            done_flag_d = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
    endcase

    // done marks the first cycle of each DONE visit, including a zero-length
    // restart issued while already sitting in DONE.
    done_d = (state_d == DONE) && ((state_q != DONE) || start);
    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      expect_q    <= '0;
      beat_cnt_q  <= '0;
      checksum_q  <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      done_flag_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      beat_cnt_q  <= beat_cnt_d;
      checksum_q  <= checksum_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      done_flag_q <= done_flag_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign checksum  = checksum_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_flag = done_flag_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_simulation_result_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simulation_result_stream_sink
//  Purpose  : Directed self-checking bench for simulation_result_stream_sink.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simulation_result_stream_sink;

  localparam int DW = 256;
  localparam int CW = 21;
  localparam int TO = 4096;

  logic          clk;
  logic          rst;
  logic          DMA_write_valid;
  logic [CW-1:0] expect_num;
  logic [DW-1:0] S_Data;
  logic          S_Valid;
  logic          S_Ready;
  logic [CW-1:0] beat_cnt;
  logic [31:0]   checksum;
  logic          busy;
  logic          done;
  logic          done_flag;
  logic          error;

  int n_tests;
  int n_fail;

  logic [31:0] exp_sum;

  simulation_result_stream_sink #(
    .DATA_WIDTH     (DW),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .DMA_write_valid (DMA_write_valid),
    .expect_num      (expect_num),
    .S_Data          (S_Data),
    .S_Valid         (S_Valid),
    .S_Ready         (S_Ready),
    .beat_cnt        (beat_cnt),
    .checksum        (checksum),
    .busy            (busy),
    .done            (done),
    .done_flag       (done_flag),
    .error           (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_sum(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] f;
    f = 32'd0;
    for (int i = 0; i < DW/32; i++) f = f ^ d[32*i +: 32];
    return {c[30:0], c[31]} ^ f;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] splat(input logic [31:0] w);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = w;
    return d;
  endfunction

  task automatic start(input int n);
    DMA_write_valid = 1'b1;
    expect_num      = CW'(n);
    step();
    DMA_write_valid = 1'b0;
    exp_sum         = 32'd0;
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send_beat(input logic [DW-1:0] d);
    int guard;
    S_Data  = d;
    S_Valid = 1'b1;
    guard   = 0;
    while (!S_Ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      check_eq("ready_wait_timeout", 64'(guard), 64'd0);
    end else begin
      exp_sum = next_sum(exp_sum, d);
      step();
    end
    S_Valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    n_tests         = 0;
    n_fail          = 0;
    exp_sum         = 32'd0;
    rst             = 1'b0;
    DMA_write_valid = 1'b0;
    expect_num      = '0;
    S_Valid         = 1'b1;
    S_Data          = rand_data();

    // Reset state with valid asserted
    #12;
    check_eq("rst_ready",    64'(S_Ready),  64'd0);
    check_eq("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check_eq("rst_checksum", 64'(checksum), 64'd0);
    check_eq("rst_error",    64'(error),    64'd0);
    check_eq("rst_busy",     64'(busy),     64'd0);
    #11;
    rst = 1'b1;
    step();
    check_eq("idle_ready", 64'(S_Ready), 64'd0);
    S_Valid = 1'b0;

    // Four beats of all-equal words: fold is zero for every beat
    start(4);
    check_eq("t1_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 4; k++) send_beat(splat(32'(k)));
    check_eq("t1_beat_cnt",  64'(beat_cnt),  64'd4);
    check_eq("t1_checksum",  64'(checksum),  64'd0);
    check_eq("t1_done",      64'(done),      64'd1);
    check_eq("t1_done_flag", 64'(done_flag), 64'd1);
    check_eq("t1_ready_off", 64'(S_Ready),   64'd0);
    check_eq("t1_busy_off",  64'(busy),      64'd0);
    step();
    check_eq("t1_done_once", 64'(done),      64'd0);

    // Rotation check with a hand-picked pattern
    start(2);
    check_eq("t2_flag_clr", 64'(done_flag), 64'd0);
    d = '0;
    d[31:0] = 32'h8000_0001;
    send_beat(d);
    check_eq("t2_sum0", 64'(checksum), 64'h8000_0001);
    send_beat('0);
    check_eq("t2_sum1", 64'(checksum), 64'h0000_0003);

    // Valid pattern 1,0,1,0,1 then extra valid beats that must be refused
    start(3);
    send_beat(rand_data());
    step();
    send_beat(rand_data());
    step();
    send_beat(rand_data());
    check_eq("t3_done_flag", 64'(done_flag), 64'd1);
    S_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      S_Data = rand_data();
      step();
    end
    S_Valid = 1'b0;
    check_eq("t3_beat_cnt",  64'(beat_cnt), 64'd3);
    check_eq("t3_checksum",  64'(checksum), 64'(exp_sum));

    // Stall timeout after five beats, then recovery
    start(10);
    DMA_write_valid = 1'b1;
    expect_num      = CW'(1);
    step();
    DMA_write_valid = 1'b0;
    check_eq("t4_recv_ignores_start", 64'(busy), 64'd1);
    for (int k = 0; k < 5; k++) send_beat(rand_data());
    check_eq("t4_cnt5",     64'(beat_cnt), 64'd5);
    check_eq("t4_still_busy", 64'(busy),   64'd1);
    for (int k = 0; k < TO - 2; k++) step();
    check_eq("t4_no_err_early", 64'(error), 64'd0);
    step();
    step();
    check_eq("t4_error",    64'(error),    64'd1);
    check_eq("t4_busy_off", 64'(busy),     64'd0);
    check_eq("t4_cnt_hold", 64'(beat_cnt), 64'd5);
    check_eq("t4_sum_hold", 64'(checksum), 64'(exp_sum));
    S_Valid = 1'b1;
    S_Data  = rand_data();
    check_eq("t4_err_ready", 64'(S_Ready), 64'd0);
    step();
    S_Valid = 1'b0;
    check_eq("t4_err_cnt",  64'(beat_cnt), 64'd5);
    start(2);
    check_eq("t4_err_clr",  64'(error),    64'd0);
    check_eq("t4_cnt_clr",  64'(beat_cnt), 64'd0);
    check_eq("t4_sum_clr",  64'(checksum), 64'd0);
    check_eq("t4_rearm",    64'(busy),     64'd1);
    send_beat(rand_data());
    send_beat(rand_data());
    check_eq("t4_redone",   64'(done),     64'd1);
    check_eq("t4_resum",    64'(checksum), 64'(exp_sum));

    // Zero-length transfer, issued while already in DONE
    S_Valid = 1'b1;
    S_Data  = rand_data();
    step();
    start(0);
    check_eq("t5_done",     64'(done),     64'd1);
    check_eq("t5_busy",     64'(busy),     64'd0);
    check_eq("t5_ready",    64'(S_Ready),  64'd0);
    check_eq("t5_cnt",      64'(beat_cnt), 64'd0);
    step();
    step();
    check_eq("t5_done_end", 64'(done),     64'd0);
    check_eq("t5_cnt_end",  64'(beat_cnt), 64'd0);
    S_Valid = 1'b0;

`ifdef SIM_SINK_STALL_INJECT_EN
    // Long continuous-valid run under injected back-pressure
    begin
      int acc;
      int guard;
      start(1000);
      acc   = 0;
      guard = 0;
      S_Valid = 1'b1;
      while (!done && guard < 3000) begin
        S_Data = rand_data();
        #0;
        if (S_Ready) begin
          exp_sum = next_sum(exp_sum, S_Data);
          acc++;
        end
        step();
        guard++;
      end
      S_Valid = 1'b0;
      check_eq("t6_accepts", 64'(acc),      64'd1000);
      check_eq("t6_cnt",     64'(beat_cnt), 64'd1000);
      check_eq("t6_sum",     64'(checksum), 64'(exp_sum));
      check_eq("t6_error",   64'(error),    64'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
